// File: rtl/loader_pkg.sv
// Shared definitions for the external-memory loader.
// Holds the header opcode encodings, the header field positions and the
// loader state enum used by ext_mem_loader.
package loader_pkg;

   localparam int LD_DATA_W = 32;
   localparam int LD_ADDR_W = 16;
   localparam int LD_CNT_W  = 14;

   // Header layout: [31:30] op, [29:16] word count, [15:0] start word index
   localparam int HDR_OP_HI  = 31;
   localparam int HDR_OP_LO  = 30;
   localparam int HDR_CNT_LO = 16;
   localparam int HDR_IDX_LO = 0;

   typedef enum logic [1:0] {
      OP_WR_IMEM = 2'b00,
      OP_WR_DMEM = 2'b01,
      OP_RD_DMEM = 2'b10,
      OP_RUN     = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      WR_IMEM,
      WR_DMEM,
      RD_ISSUE,
      RD_WAIT,
      RD_SEND,
      RUN_LEN,
      RUN
   } state_e;

endpackage

// File: rtl/run_timer.sv
// Loadable down-counter shared by the RUN phase and the sram read wait.
// Ports:
//   clk, arst_n   clock, synchronous active-low reset
//   load          load load_val (has priority over en)
//   load_val      starting count
//   en            decrement by one while non-zero
//   zero          count has reached zero (terminal count)
module run_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   assign zero = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (en && !zero)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (!arst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side driver for the cpu external memory ports. Parses a 32-bit
// command stream to load instruction and data memory, runs the cpu for a
// programmed number of cycles and streams data-memory words back out.
// Ports:
//   clk, arst_n                clock, synchronous active-low reset
//   s_valid/s_data/s_ready     command and write-data stream in
//   m_valid/m_data/m_ready     readback stream out
//   cpu_enable                 cpu run enable
//   addr_ext..rdata_ext        imem port (write only, reads tied off)
//   addr_ext_2..rdata_ext_2    dmem port (write and read)
//   busy                       any state other than IDLE
//   done                       one-cycle pulse after a command completes
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a header word
// WR_IMEM  | each accepted word is written to imem, idx++ count--
// WR_DMEM  | each accepted word is written to dmem, idx++ count--
// RD_ISSUE | one-cycle dmem read strobe
// RD_WAIT  | wait out the sram read latency, capture read data
// RD_SEND  | hold the captured word on m_data until accepted
// RUN_LEN  | waiting for the run-length word
// RUN      | cpu_enable high until the timer reaches zero
module ext_mem_loader
   import loader_pkg::*;
#(
   parameter int DATA_W = LD_DATA_W,
   parameter int ADDR_W = LD_ADDR_W,
   parameter int CNT_W  = LD_CNT_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              cpu_enable,
   output logic [31:0]       addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [31:0]       wdata_ext,
   input  logic [31:0]       rdata_ext,
   output logic [31:0]       addr_ext_2,
   output logic              wen_ext_2,
   output logic              ren_ext_2,
   output logic [31:0]       wdata_ext_2,
   input  logic [31:0]       rdata_ext_2,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mdata_q, mdata_d;
   logic              done_q, done_d;

   logic              tmr_load, tmr_en, tmr_zero;
   logic [DATA_W-1:0] tmr_val;

   logic              s_xfer, m_xfer;
   op_e               hdr_op;
   logic [CNT_W-1:0]  hdr_cnt;
   logic [ADDR_W-1:0] hdr_idx;
   logic [31:0]       byte_addr;
   logic              unused_rdata;

   assign unused_rdata = ^rdata_ext;

   assign hdr_op    = op_e'(s_data[HDR_OP_HI:HDR_OP_LO]);
   assign hdr_cnt   = s_data[HDR_CNT_LO +: CNT_W];
   assign hdr_idx   = s_data[HDR_IDX_LO +: ADDR_W];
   assign byte_addr = {{(32-ADDR_W-2){1'b0}}, idx_q, 2'b00};

   assign s_ready = (state_q == IDLE) || (state_q == WR_IMEM) ||
                    (state_q == WR_DMEM) || (state_q == RUN_LEN);
   assign s_xfer  = s_valid && s_ready;
   assign m_valid = (state_q == RD_SEND);
   assign m_xfer  = m_valid && m_ready;
   assign m_data  = mdata_q;

   // Write strobes follow the accepted word combinationally so the sram
   // captures it on the same edge the loader consumes it.
   assign wen_ext     = (state_q == WR_IMEM) && s_valid;
   assign ren_ext     = 1'b0;
   assign addr_ext    = wen_ext ? byte_addr : '0;
   assign wdata_ext   = wen_ext ? s_data : '0;

   assign wen_ext_2   = (state_q == WR_DMEM) && s_valid;
   assign ren_ext_2   = (state_q == RD_ISSUE);
   assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ? byte_addr : '0;
   assign wdata_ext_2 = wen_ext_2 ? s_data : '0;

   assign cpu_enable  = (state_q == RUN);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;

   run_timer #(.W(DATA_W)) u_timer (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      mdata_d  = mdata_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_xfer) begin
               idx_d = hdr_idx;
               cnt_d = hdr_cnt;
               if (hdr_op == OP_RUN)
                  state_d = RUN_LEN;
               else if (hdr_cnt == '0)
                  done_d = 1'b1;
               else begin
                  case (hdr_op)
                     OP_WR_IMEM: state_d = WR_IMEM;
                     OP_WR_DMEM: state_d = WR_DMEM;
                     default:    state_d = RD_ISSUE;
                  endcase
               end
            end
         end
         WR_IMEM, WR_DMEM: begin
            if (s_xfer) begin
               idx_d = idx_q + ADDR_W'(1);
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         RD_ISSUE: begin
            // Timer counts RD_LAT-1 down to zero, giving RD_LAT wait cycles.
            tmr_load = 1'b1;
            tmr_val  = DATA_W'(RD_LAT - 1);
            state_d  = RD_WAIT;
         end
         RD_WAIT: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               mdata_d = rdata_ext_2;
               state_d = RD_SEND;
            end
         end
         RD_SEND: begin
            if (m_xfer) begin
               idx_d = idx_q + ADDR_W'(1);
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else
                  state_d = RD_ISSUE;
            end
         end
         RUN_LEN: begin
            if (s_xfer) begin
               if (s_data == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  // Loading N-1 and leaving on zero keeps RUN for exactly N cycles.
                  tmr_load = 1'b1;
                  tmr_val  = s_data - DATA_W'(1);
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         mdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         mdata_q <= mdata_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_ext_mem_loader.sv
// Scoreboard bench for ext_mem_loader: expected memory writes and readback
// words are queued as stimulus is driven and popped as the DUT produces them.
module tb_ext_mem_loader;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready = 1'b1;
   logic        cpu_enable;
   logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
   logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic [31:0] rdata_ext = '0;
   logic [31:0] rdata_ext_2 = '0;
   logic        busy, done;

   always #5 clk = ~clk;

   ext_mem_loader dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_ready     (m_ready),
      .cpu_enable  (cpu_enable),
      .addr_ext    (addr_ext),
      .wen_ext     (wen_ext),
      .ren_ext     (ren_ext),
      .wdata_ext   (wdata_ext),
      .rdata_ext   (rdata_ext),
      .addr_ext_2  (addr_ext_2),
      .wen_ext_2   (wen_ext_2),
      .ren_ext_2   (ren_ext_2),
      .wdata_ext_2 (wdata_ext_2),
      .rdata_ext_2 (rdata_ext_2),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         q_imem[$];
   wr_t         q_dmem[$];
   logic [31:0] q_rd[$];
   logic [31:0] wbuf[$];

   logic [31:0] dmem [0:65535];
   logic [31:0] sh   [0:65535];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0, done_cyc = 0;
   int en_cnt = 0, last_en_cyc = 0;
   int strobe_cnt = 0, excl_viol = 0;
   int rd_seen = 0, hold_cnt = 0;
   int stall_word = -1;
   int stall_len = 5;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // dmem sram (1-cycle read latency) plus a toy cpu: each enabled cycle
   // accumulates word 1 into word 0.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wen_ext_2) dmem[addr_ext_2[17:2]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[17:2]];
      if (cpu_enable) dmem[0] <= dmem[0] + dmem[1];
   end

   // Readback backpressure: hold m_ready low stall_len cycles on word stall_word.
   always @(posedge clk) begin : stall_drv
      int used;
      int last_word;
      #1;
      if (stall_word != last_word) begin
         used = 0;
         last_word = stall_word;
      end
      if (m_valid && rd_seen == stall_word && used < stall_len) begin
         m_ready = 1'b0;
         used++;
      end else
         m_ready = 1'b1;
   end

   always @(negedge clk) begin : mon
      wr_t         e;
      logic [31:0] r;
      logic        hold_v;
      logic [31:0] hold_d;
      if (arst_n) begin
         if (wen_ext) begin
            if (q_imem.size() == 0) chk("imem_unexpected", 64'(addr_ext), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               e = q_imem.pop_front();
               chk("imem_addr", 64'(addr_ext), 64'(e.a));
               chk("imem_data", 64'(wdata_ext), 64'(e.d));
            end
         end
         if (wen_ext_2) begin
            if (q_dmem.size() == 0) chk("dmem_unexpected", 64'(addr_ext_2), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               e = q_dmem.pop_front();
               chk("dmem_addr", 64'(addr_ext_2), 64'(e.a));
               chk("dmem_data", 64'(wdata_ext_2), 64'(e.d));
            end
         end
         if (m_valid) begin
            if (hold_v) chk("m_hold", 64'(m_data), 64'(hold_d));
            if (m_ready) begin
               hold_v = 1'b0;
               if (q_rd.size() == 0) chk("rd_unexpected", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
               else begin
                  r = q_rd.pop_front();
                  chk("rd_data", 64'(m_data), 64'(r));
               end
               rd_seen++;
            end else begin
               hold_v = 1'b1;
               hold_d = m_data;
               hold_cnt++;
            end
         end else
            hold_v = 1'b0;
         if (cpu_enable) begin
            en_cnt++;
            last_en_cyc = cyc;
         end
         if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2) strobe_cnt++;
         if (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) excl_viol++;
         if (done && m_valid) excl_viol++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else
         hold_v = 1'b0;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] w);
      bit ok;
      int k;
      s_valid = 1'b1;
      s_data  = w;
      ok = 1'b0;
      k  = 0;
      while (!ok && k < 300) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk);
         #1;
         k++;
      end
      if (!ok) chk("s_ready_timeout", 64'(ok), 64'd1);
      s_valid = 1'b0;
      s_data  = '0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int k;
      k = 0;
      while (done_cnt == d0 && k < 2000) begin
         tick(1);
         k++;
      end
      tick(2);
      chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic wr_mem(input bit dm, input logic [15:0] idx, input string tag);
      int d0;
      logic [15:0] ix;
      wr_t e;
      d0 = done_cnt;
      send({dm ? 2'b01 : 2'b00, 14'(wbuf.size()), idx});
      for (int i = 0; i < wbuf.size(); i++) begin
         ix  = idx + 16'(i);
         e.a = {14'b0, ix, 2'b00};
         e.d = wbuf[i];
         if (dm) begin
            q_dmem.push_back(e);
            sh[ix] = wbuf[i];
         end else
            q_imem.push_back(e);
         send(wbuf[i]);
      end
      wait_done(d0, tag);
   endtask

   task automatic rd_mem(input logic [15:0] idx, input int n, input string tag);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < n; i++) q_rd.push_back(sh[16'(idx + 16'(i))]);
      send({2'b10, 14'(n), idx});
      wait_done(d0, tag);
      chk({tag, "_all_read"}, 64'(q_rd.size()), 64'd0);
   endtask

   task automatic run(input int n, input string tag);
      int d0;
      d0 = done_cnt;
      sh[0] = sh[0] + 32'(n) * sh[1];
      send(32'hC000_0000);
      send(32'(n));
      wait_done(d0, tag);
   endtask

   initial begin : stim
      int e0, s0, d0;

      // reset state
      arst_n = 1'b0;
      tick(3);
      chk("rst_s_ready", 64'(s_ready), 64'd1);
      chk("rst_ctrl", 64'({busy, m_valid, cpu_enable, done, wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
      chk("rst_addr", 64'({addr_ext, addr_ext_2}), 64'd0);
      arst_n = 1'b1;
      tick(1);

      // imem load at word index 4
      wbuf = '{32'hAABB_0001, 32'hAABB_0002};
      wr_mem(1'b0, 16'h0004, "imem");
      chk("imem_all_written", 64'(q_imem.size()), 64'd0);

      // dmem writes at the top of the index space, then a wrapping burst
      wbuf = '{32'h1234_5678};
      wr_mem(1'b1, 16'hFFFF, "dmem_top");
      wbuf = '{32'h0000_0001};
      wr_mem(1'b1, 16'h0000, "dmem_zero");
      wbuf = '{32'hCAFE_0000, 32'hCAFE_0001};
      wr_mem(1'b1, 16'hFFFF, "dmem_wrap");
      chk("dmem_all_written", 64'(q_dmem.size()), 64'd0);

      // readback of 3 words with a 5-cycle stall on the second
      wbuf = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002};
      wr_mem(1'b1, 16'h0000, "dmem_rdprep");
      e0 = hold_cnt;
      stall_word = rd_seen + 1;
      rd_mem(16'h0000, 3, "rd3");
      chk("rd3_stall_cycles", 64'(hold_cnt - e0), 64'd5);

      // run for 10 cycles
      e0 = en_cnt;
      s0 = strobe_cnt;
      run(10, "run10");
      chk("run10_enable_cycles", 64'(en_cnt - e0), 64'd10);
      chk("run10_done_after_fall", 64'(done_cyc - last_en_cyc), 64'd1);
      chk("run10_no_strobes", 64'(strobe_cnt - s0), 64'd0);

      // zero-length run and zero-count write
      e0 = en_cnt;
      run(0, "run0");
      chk("run0_no_enable", 64'(en_cnt - e0), 64'd0);
      d0 = done_cnt;
      s0 = strobe_cnt;
      send(32'h0000_0010);
      wait_done(d0, "wr_cnt0");
      chk("wr_cnt0_no_strobes", 64'(strobe_cnt - s0), 64'd0);

      // reset after 1 of 4 dmem words
      send(32'h4004_0020);
      q_dmem.push_back('{a: 32'h0000_0080, d: 32'h5555_0000});
      sh[16'h0020] = 32'h5555_0000;
      send(32'h5555_0000);
      chk("mid_wr_busy", 64'(busy), 64'd1);
      arst_n = 1'b0;
      tick(1);
      chk("mid_wr_rst_ctrl", 64'({busy, cpu_enable, wen_ext, wen_ext_2, ren_ext_2, m_valid}), 64'd0);
      chk("mid_wr_rst_s_ready", 64'(s_ready), 64'd1);
      arst_n = 1'b1;
      tick(1);

      // reset in the middle of a run
      d0 = done_cnt;
      send(32'hC000_0000);
      send(32'd20);
      tick(3);
      chk("mid_run_enabled", 64'(cpu_enable), 64'd1);
      arst_n = 1'b0;
      tick(1);
      chk("mid_run_rst_ctrl", 64'({busy, cpu_enable, wen_ext, wen_ext_2, ren_ext_2, m_valid}), 64'd0);
      chk("mid_run_rst_s_ready", 64'(s_ready), 64'd1);
      arst_n = 1'b1;
      tick(25);
      chk("mid_run_no_done", 64'(done_cnt - d0), 64'd0);

      // full flow: imem, dmem, run, readback against the accumulate model
      wbuf = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8133};
      wr_mem(1'b0, 16'h0100, "flow_imem");
      wbuf = '{32'd5, 32'd3, 32'hDEAD_0002, 32'hDEAD_0003};
      wr_mem(1'b1, 16'h0000, "flow_dmem");
      run(7, "flow_run");
      rd_mem(16'h0000, 4, "flow_rd");

      chk("exclusivity", 64'(excl_viol), 64'd0);
      chk("queues_drained", 64'(q_imem.size() + q_dmem.size() + q_rd.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
